// File: rtl/dm_responder_pkg.sv
// Shared constants and trace-record layout for the data-memory responder.
package dm_responder_pkg;

  localparam int unsigned MemWordsDefault = 3072;
  localparam int unsigned TrcDepthDefault = 8;
  // First byte address beyond the backed range for the default memory size.
  localparam logic [31:0] AddrLimitDefault = 32'h0000_3000;

  localparam int unsigned PcW     = 32;
  localparam int unsigned AddrW   = 32;
  localparam int unsigned DataW   = 32;
  localparam int unsigned BeW     = 4;
  localparam int unsigned MemIdxW = 12;

  typedef struct packed {
    logic [PcW-1:0]   pc;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
    logic [BeW-1:0]   byteen;
  } trc_rec_t;

  localparam int unsigned TrcRecW = $bits(trc_rec_t);

  // Byte-lane merge of store data into an existing word.
  function automatic logic [DataW-1:0] merge_word(input logic [DataW-1:0] old_word,
                                                  input logic [DataW-1:0] wdata,
                                                  input logic [BeW-1:0]   byteen);
    logic [DataW-1:0] res;
    res = old_word;
    for (int i = 0; i < BeW; i++) begin
      if (byteen[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_responder_trc_fifo.sv
// Store-trace FIFO: registered storage, no fall-through, extra pointer bit
// distinguishes full from empty. Depth must be a power of two (>= 2).
module trc_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] store_q [Depth];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                 (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign rdata = store_q[rptr_q[PtrW-1:0]];

  // Pointer update; wrap is implicit in the PtrW+1-bit counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Entry storage, no reset needed: pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) store_q[wptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: zero-latency read, byte-lane stores, store trace,
// drop counter and sticky out-of-range flag.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MemWordsDefault,
  parameter int unsigned TRC_DEPTH = TrcDepthDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        trc_valid,
  input  logic        trc_ready,
  output logic [31:0] trc_pc,
  output logic [31:0] trc_addr,
  output logic [31:0] trc_data,
  output logic [3:0]  trc_byteen,
  output logic [15:0] drop_cnt,
  output logic        addr_err
);

  localparam logic [32:0] AddrLimit = 33'(MEM_WORDS) << 2;

  logic [DataW-1:0]   mem_q [MEM_WORDS];
  logic [MemIdxW-1:0] mem_idx;
  logic               in_range;
  logic [DataW-1:0]   rd_word, merged;
  logic               push, pop, drop;
  logic               fifo_full, fifo_empty;
  trc_rec_t           rec_in, rec_head;
  logic [15:0]        drop_cnt_q;
  logic               addr_err_q;

  assign mem_idx  = m_data_addr[MemIdxW+1:2];
  assign in_range = ({1'b0, m_data_addr} < AddrLimit);
  assign rd_word  = in_range ? mem_q[mem_idx] : '0;
  assign merged   = merge_word(rd_word, m_data_wdata, m_data_byteen);

  assign push = (m_data_byteen != '0) && in_range;
  assign pop  = trc_valid && trc_ready;
  assign drop = push && fifo_full && !pop;

  assign rec_in = '{pc:     m_inst_addr,
                    addr:   {m_data_addr[31:2], 2'b00},
                    data:   merged,
                    byteen: m_data_byteen};

  assign m_data_rdata = rd_word;

  // Backing store: cleared by reset, lane-merged write on in-range stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[mem_idx] <= merged;
    end
  end

  // Saturating drop counter and sticky range-error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (!in_range) addr_err_q <= 1'b1;
    end
  end

  trc_fifo #(
    .Width (TrcRecW),
    .Depth (TRC_DEPTH)
  ) u_trc_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (rec_in),
    .pop   (pop),
    .rdata (rec_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign trc_valid  = !fifo_empty;
  assign trc_pc     = rec_head.pc;
  assign trc_addr   = rec_head.addr;
  assign trc_data   = rec_head.data;
  assign trc_byteen = rec_head.byteen;
  assign drop_cnt   = drop_cnt_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench with a trace scoreboard: stores push expected records, a
// monitor pops and compares on every accepted trace handshake.
module tb_dm_responder;
  import dm_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr, m_data_wdata, m_inst_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic        trc_valid, trc_ready;
  logic [31:0] trc_pc, trc_addr, trc_data;
  logic [3:0]  trc_byteen;
  logic [15:0] drop_cnt;
  logic        addr_err;

  trc_rec_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_responder dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .trc_valid     (trc_valid),
    .trc_ready     (trc_ready),
    .trc_pc        (trc_pc),
    .trc_addr      (trc_addr),
    .trc_data      (trc_data),
    .trc_byteen    (trc_byteen),
    .drop_cnt      (drop_cnt),
    .addr_err      (addr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a store (inputs change at posedge+1); push the expected record if it
  // should reach the trace.
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] pc, input bit exp_push, input logic [31:0] exp_data);
    trc_rec_t r;
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    m_inst_addr   = pc;
    if (exp_push) begin
      r = '{pc: pc, addr: {a[31:2], 2'b00}, data: exp_data, byteen: be};
      sb.push_back(r);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_data_byteen = 4'b0000;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    check("trc_valid_after_drain", {31'b0, trc_valid}, 0);
  endtask

  // Monitor: every accepted handshake must match the oldest expected record.
  always @(negedge clk) begin
    trc_rec_t exp_r;
    if (reset && trc_valid && trc_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL trace_unexpected: got pc=%h addr=%h data=%h be=%b expected no entry",
                 trc_pc, trc_addr, trc_data, trc_byteen);
      end else begin
        exp_r = sb.pop_front();
        if ({trc_pc, trc_addr, trc_data, trc_byteen} !== exp_r) begin
          n_err++;
          $display("FAIL trace_entry: got pc=%h addr=%h data=%h be=%b expected pc=%h addr=%h data=%h be=%b",
                   trc_pc, trc_addr, trc_data, trc_byteen,
                   exp_r.pc, exp_r.addr, exp_r.data, exp_r.byteen);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    m_data_addr = 32'h0; m_data_wdata = 32'h0; m_data_byteen = 4'b0; m_inst_addr = 32'h0;
    trc_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_trc_valid", {31'b0, trc_valid}, 0);
    check("reset_drop_cnt", {16'b0, drop_cnt}, 0);
    check("reset_addr_err", {31'b0, addr_err}, 0);
    check("reset_rdata", m_data_rdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Full-word store; read before the edge still sees the old word.
    drive(32'h10, 32'hAABBCCDD, 4'b1111, 32'h100, 1'b1, 32'hAABBCCDD);
    #1;
    check("pre_edge_old_word", m_data_rdata, 32'h0);
    tick();
    check("full_store_read", m_data_rdata, 32'hAABBCCDD);

    // Upper-half store at a misaligned address: lanes 2-3 replaced with 0.
    drive(32'h12, 32'h00001122, 4'b1100, 32'h104, 1'b1, 32'h0000CCDD);
    tick();
    check("half_store_read", m_data_rdata, 32'h0000CCDD);
    repeat (3) @(posedge clk);
    #1;
    check("first_two_drained", sb.size(), 0);

    // Fill with consumer stalled: 8 queue, 2 drop.
    trc_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(32'h20 + 32'(4 * i), 32'h1000 + 32'(i), 4'b1111, 32'h200 + 32'(4 * i),
            (i < 8), 32'h1000 + 32'(i));
      tick();
    end
    check("drop_cnt_after_10", {16'b0, drop_cnt}, 32'd2);
    check("full_trc_valid", {31'b0, trc_valid}, 1);
    check("stalled_head_pc", trc_pc, 32'h200);
    check("stalled_head_data", trc_data, 32'h1000);

    // Push and pop on the same edge while full: no drop.
    trc_ready = 1'b1;
    drive(32'h48, 32'h2000, 4'b1111, 32'h300, 1'b1, 32'h2000);
    tick();
    trc_ready = 1'b0;
    check("simul_push_pop_drop_cnt", {16'b0, drop_cnt}, 32'd2);
    check("new_head_pc", trc_pc, 32'h204);
    // Still full: one more stalled store must drop.
    drive(32'h4C, 32'h3000, 4'b1111, 32'h304, 1'b0, 32'h0);
    tick();
    check("still_full_drop", {16'b0, drop_cnt}, 32'd3);

    trc_ready = 1'b1;
    wait_drain();

    // Out-of-range store.
    drive(32'h3000, 32'hDEADBEEF, 4'b1111, 32'h400, 1'b0, 32'h0);
    #1;
    check("oor_rdata_pre", m_data_rdata, 32'h0);
    tick();
    check("oor_addr_err", {31'b0, addr_err}, 1);
    check("oor_rdata_post", m_data_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("oor_no_push", {31'b0, trc_valid}, 0);
    m_data_addr = 32'h10;
    #1;
    check("oor_mem_unchanged", m_data_rdata, 32'h0000CCDD);
    @(posedge clk);
    #1;
    check("addr_err_sticky", {31'b0, addr_err}, 1);

    // Reset with three entries queued.
    trc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h50 + 32'(4 * i), 32'h5000 + 32'(i), 4'b1111, 32'h500 + 32'(4 * i), 1'b0, 32'h0);
      tick();
    end
    check("queued_before_reset", {31'b0, trc_valid}, 1);
    reset = 1'b0;
    m_data_addr = 32'h10;
    #1;
    check("midreset_trc_valid", {31'b0, trc_valid}, 0);
    check("midreset_drop_cnt", {16'b0, drop_cnt}, 0);
    check("midreset_addr_err", {31'b0, addr_err}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    trc_ready = 1'b1;
    #1;
    check("post_reset_word10", m_data_rdata, 32'h0);

    // Normal operation resumes after release.
    drive(32'h10, 32'h12345678, 4'b0011, 32'h600, 1'b1, 32'h00005678);
    tick();
    check("resume_read", m_data_rdata, 32'h00005678);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
